// File: rtl/arith_pkg.sv
// Shared arithmetic-library types: state encoding for the sequential divider
// (and the planned sequential multiplier).
package arith_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} t_div_state;

endpackage

// File: rtl/rippleborrowsubtractor.sv
// Ripple-borrow subtractor: out_diff = in_a - in_b modulo 2**BITS.
// Callers derive the borrow from the top bit of a widened difference.
module rippleborrowsubtractor #(
  parameter int unsigned BITS = 17
) (
  input  logic [BITS-1:0] in_a,
  input  logic [BITS-1:0] in_b,
  output logic [BITS-1:0] out_diff
);

  logic brw;

  always_comb begin
    brw      = 1'b0;
    out_diff = '0;
    for (int i = 0; i < BITS; i++) begin
      out_diff[i] = in_a[i] ^ in_b[i] ^ brw;
      brw         = (~in_a[i] & in_b[i]) | (~in_a[i] & brw) | (in_b[i] & brw);
    end
  end

endmodule

// File: rtl/divider_seq_ctrl.sv
// Sequential restoring unsigned divider, one quotient bit per clock.
// Optional divide-by-zero short cut and error flag: define DIVIDER_ZERO_CHECK_EN.
module divider_seq_ctrl #(
  parameter int unsigned BITS = 16
) (
  input  logic            in_clk,
  input  logic            in_rst,
  input  logic            in_start,
  input  logic [BITS-1:0] in_dividend,
  input  logic [BITS-1:0] in_divisor,
  output logic            out_busy,
  output logic            out_valid,
  output logic [BITS-1:0] out_quot,
  output logic [BITS-1:0] out_rem,
  output logic            out_err
);
  import arith_pkg::*;

  localparam int unsigned CNT_BITS = $clog2(BITS + 1);

  t_div_state            state_q, state_d;
  logic [BITS-1:0]       dvd_q, dvd_d;
  logic [BITS-1:0]       dsr_q, dsr_d;
  logic [BITS-1:0]       rem_q, rem_d;
  logic [BITS-1:0]       quot_q, quot_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic [BITS-1:0]       quot_out_q, quot_out_d;
  logic [BITS-1:0]       rem_out_q, rem_out_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic [BITS:0]         trial;
  logic [BITS:0]         diff;

  // The partial remainder stays below the divisor, so BITS bits of it plus the
  // next dividend bit always fit the BITS+1 wide trial value.
  assign trial = {rem_q, dvd_q[BITS-1]};

  rippleborrowsubtractor #(
    .BITS(BITS + 1)
  ) u_sub (
    .in_a    (trial),
    .in_b    ({1'b0, dsr_q}),
    .out_diff(diff)
  );

`ifdef DIVIDER_ZERO_CHECK_EN
  logic err_q, err_d;
  assign out_err = err_q;
`else
  assign out_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    dvd_d      = dvd_q;
    dsr_d      = dsr_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    cnt_d      = cnt_q;
    quot_out_d = quot_out_q;
    rem_out_d  = rem_out_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
`ifdef DIVIDER_ZERO_CHECK_EN
    err_d      = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_start) begin
          dvd_d   = in_dividend;
          dsr_d   = in_divisor;
          rem_d   = '0;
          quot_d  = '0;
          cnt_d   = CNT_BITS'(BITS);
          valid_d = 1'b0;
          busy_d  = 1'b1;
          state_d = LOAD;
`ifdef DIVIDER_ZERO_CHECK_EN
          err_d   = 1'b0;
`endif
        end
      end
      LOAD: begin
        state_d = CALC;
`ifdef DIVIDER_ZERO_CHECK_EN
        if (dsr_q == '0) begin
          quot_d  = '1;
          rem_d   = dvd_q;
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end
`endif
      end
      CALC: begin
        dvd_d = {dvd_q[BITS-2:0], 1'b0};
        // Top bit of the widened difference is the borrow of the trial subtraction.
        if (diff[BITS]) begin
          rem_d  = trial[BITS-1:0];
          quot_d = {quot_q[BITS-2:0], 1'b0};
        end else begin
          rem_d  = diff[BITS-1:0];
          quot_d = {quot_q[BITS-2:0], 1'b1};
        end
        cnt_d = cnt_q - CNT_BITS'(1);
        if (cnt_q == CNT_BITS'(1)) begin
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        quot_out_d = quot_q;
        rem_out_d  = rem_q;
        valid_d    = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state_q    <= IDLE;
      dvd_q      <= '0;
      dsr_q      <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      cnt_q      <= '0;
      quot_out_q <= '0;
      rem_out_q  <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
`ifdef DIVIDER_ZERO_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      dvd_q      <= dvd_d;
      dsr_q      <= dsr_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      cnt_q      <= cnt_d;
      quot_out_q <= quot_out_d;
      rem_out_q  <= rem_out_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
`ifdef DIVIDER_ZERO_CHECK_EN
      err_q      <= err_d;
`endif
    end
  end

  assign out_busy  = busy_q;
  assign out_valid = valid_q;
  assign out_quot  = quot_out_q;
  assign out_rem   = rem_out_q;

endmodule

// File: tb/tb_divider_seq_ctrl.sv
// Bench for divider_seq_ctrl: arithmetic reference model checked every cycle,
// plus directed vectors with literal expected results.
module tb_divider_seq_ctrl;

  localparam int unsigned BITS = 16;
`ifdef DIVIDER_ZERO_CHECK_EN
  localparam bit ZC = 1'b1;
`else
  localparam bit ZC = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [BITS-1:0] dividend = '0;
  logic [BITS-1:0] divisor = '0;
  logic            busy, valid, err;
  logic [BITS-1:0] quot, rem;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int busy_seen = 0;

  divider_seq_ctrl #(
    .BITS(BITS)
  ) dut (
    .in_clk     (clk),
    .in_rst     (rst_n),
    .in_start   (start),
    .in_dividend(dividend),
    .in_divisor (divisor),
    .out_busy   (busy),
    .out_valid  (valid),
    .out_quot   (quot),
    .out_rem    (rem),
    .out_err    (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at t=%0t",
               name, act, act, exp, exp, $time);
    end
  endfunction

  // Reference model: a division accepted while idle completes a fixed number of
  // edges later with plain integer quotient/remainder.
  logic            m_run, m_valid, m_err, p_err;
  int              m_left;
  logic [BITS-1:0] m_quot, m_rem, p_quot, p_rem;
  logic            m_busy;
  assign m_busy = m_run && (m_left >= 2);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run   <= 1'b0;
      m_left  <= 0;
      m_valid <= 1'b0;
      m_err   <= 1'b0;
      m_quot  <= '0;
      m_rem   <= '0;
      p_quot  <= '0;
      p_rem   <= '0;
      p_err   <= 1'b0;
    end else if (!m_run) begin
      if (start) begin
        m_run   <= 1'b1;
        m_valid <= 1'b0;
        m_left  <= (ZC && divisor == 0) ? 2 : BITS + 2;
        p_quot  <= (divisor == 0) ? '1 : dividend / divisor;
        p_rem   <= (divisor == 0) ? dividend : dividend % divisor;
        p_err   <= ZC && (divisor == 0);
      end
    end else if (m_left == 1) begin
      m_run   <= 1'b0;
      m_valid <= 1'b1;
      m_quot  <= p_quot;
      m_rem   <= p_rem;
      m_err   <= p_err;
    end else begin
      m_left <= m_left - 1;
    end
  end

  always @(negedge clk) begin
    check("busy", 32'(busy), 32'(m_busy));
    check("valid", 32'(valid), 32'(m_valid));
    check("quot", 32'(quot), 32'(m_quot));
    check("rem", 32'(rem), 32'(m_rem));
    if (m_valid) check("err", 32'(err), 32'(m_err));
  end

  task automatic launch(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    busy_seen = busy ? 1 : 0;
    check("valid_drop_on_accept", 32'(valid), 32'd0);
    @(negedge clk);
    start    = 1'b0;
    dividend = 16'hDEAD;
    divisor  = 16'h0BEE;
  endtask

  task automatic wait_done(input string name, input logic [BITS-1:0] eq,
                           input logic [BITS-1:0] er, input int elat);
    bit got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk);
      #1;
      if (busy) busy_seen++;
      if (valid) got = 1'b1;
    end
    check({name, "_done_in_time"}, 32'(got), 32'd1);
    check({name, "_latency"}, 32'(cyc - acc_cyc), 32'(elat));
    check({name, "_quot"}, 32'(quot), 32'(eq));
    check({name, "_rem"}, 32'(rem), 32'(er));
  endtask

  initial begin
    #3;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_quot", 32'(quot), 32'd0);
    check("reset_rem", 32'(rem), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    // 1: basic, latency and busy length
    launch(16'd234, 16'd123);
    wait_done("t1", 16'd1, 16'd111, 18);
    check("t1_busy_cycles", 32'(busy_seen), 32'd17);
    check("t1_err", 32'(err), 32'd0);

    // 2: assorted operands
    launch(16'd1000, 16'd7);
    wait_done("t2a", 16'd142, 16'd6, 18);
    launch(16'd5, 16'd9);
    wait_done("t2b", 16'd0, 16'd5, 18);
    launch(16'hFFFF, 16'd1);
    wait_done("t2c", 16'hFFFF, 16'd0, 18);

    // 3: start pulse during CALC is ignored
    launch(16'd100, 16'd3);
    repeat (5) @(negedge clk);
    start    = 1'b1;
    dividend = 16'd50;
    divisor  = 16'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done("t3", 16'd33, 16'd1, 18);

    // 4: reset mid-CALC aborts immediately
    launch(16'd1234, 16'd5);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t4_rst_busy", 32'(busy), 32'd0);
    check("t4_rst_valid", 32'(valid), 32'd0);
    check("t4_rst_quot", 32'(quot), 32'd0);
    check("t4_rst_rem", 32'(rem), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    launch(16'd81, 16'd9);
    wait_done("t4", 16'd9, 16'd0, 18);

    // 5: divide by zero
    launch(16'd77, 16'd0);
    wait_done("t5", 16'hFFFF, 16'd77, ZC ? 2 : 18);
    check("t5_err", 32'(err), ZC ? 32'd1 : 32'd0);
    check("t5_busy_cycles", 32'(busy_seen), ZC ? 32'd1 : 32'd17);

    // 6: back-to-back start while valid is high
    launch(16'd60000, 16'd250);
    wait_done("t6a", 16'd240, 16'd0, 18);
    launch(16'd12345, 16'd100);
    wait_done("t6b", 16'd123, 16'd45, 18);
    check("t6_err", 32'(err), 32'd0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
